// File: rtl/mem_map_pkg.sv
// Memory map and shared types for the 68K memory controller: regions, FSM states,
// the address decoder and the per-region strobe pattern.
package mem_map_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_WRAM,
    REG_CARD,
    REG_SROM,
    REG_SRAM
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_t;

  localparam logic [3:0] WRAM_BASE = 4'h1;
  localparam logic [3:0] CARD_BASE = 4'h8;
  localparam logic [3:0] CARD_LAST = 4'hB;
  localparam logic [3:0] SROM_BASE = 4'hC;
  localparam logic [3:0] SRAM_BASE = 4'hD;

  // Active-high internal strobes; the top inverts them onto the n* pins.
  typedef struct packed {
    logic wram_oeu;
    logic wram_oel;
    logic wram_weu;
    logic wram_wel;
    logic srom_oe;
    logic sram_oeu;
    logic sram_oel;
    logic sram_weu;
    logic sram_wel;
    logic crdc;
    logic crdo;
    logic crdw;
  } strobes_t;

  function automatic region_t decode_region(input logic [3:0] nib);
    region_t r;
    r = REG_NONE;
    if (nib == WRAM_BASE)
      r = REG_WRAM;
    else if (nib >= CARD_BASE && nib <= CARD_LAST)
      r = REG_CARD;
    else if (nib == SROM_BASE)
      r = REG_SROM;
    else if (nib == SRAM_BASE)
      r = REG_SRAM;
    return r;
  endfunction

  // ROM is never written, and SRAM writes are swallowed while the write lock is set.
  function automatic strobes_t region_strobes(input region_t region, input logic rw,
                                              input logic uds_n, input logic lds_n,
                                              input logic wen);
    strobes_t s;
    logic rd, wr, u, l;
    rd = rw;
    wr = ~rw;
    u  = ~uds_n;
    l  = ~lds_n;
    s  = '0;
    case (region)
      REG_WRAM: begin
        s.wram_oeu = rd & u;
        s.wram_oel = rd & l;
        s.wram_weu = wr & u;
        s.wram_wel = wr & l;
      end
      REG_SROM: s.srom_oe = rd & (u | l);
      REG_SRAM: begin
        s.sram_oeu = rd & u;
        s.sram_oel = rd & l;
        s.sram_weu = wr & u & wen;
        s.sram_wel = wr & l & wen;
      end
      REG_CARD: begin
        s.crdc = 1'b1;
        s.crdo = rd & (u | l);
        s.crdw = wr & (u | l);
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/m68k_wait_cnt.sv
// Loadable wait-state down-counter; stops at zero and flags it.
module m68k_wait_cnt #(
  parameter int WS_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [WS_W-1:0] load_val,
  output logic            zero
);

  logic [WS_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - WS_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/m68k_mem_ctrl.sv
// 68K bus decoder and memory sequencer: registered chip strobes, per-region
// wait states and nDTACK generation for WRAM, SROM, SRAM and the memory card.
module m68k_mem_ctrl
  import mem_map_pkg::*;
#(
  parameter int WS_WRAM = 0,
  parameter int WS_SROM = 2,
  parameter int WS_SRAM = 1,
  parameter int WS_CARD = 3,
  parameter int WS_W    = 3
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        M68K_RW,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        SRAM_WEN,
  output logic        nWRAM_OEU,
  output logic        nWRAM_OEL,
  output logic        nWRAM_WEU,
  output logic        nWRAM_WEL,
  output logic        nSROM_OE,
  output logic        nSRAM_OEU,
  output logic        nSRAM_OEL,
  output logic        nSRAM_WEU,
  output logic        nSRAM_WEL,
  output logic        nCRDC,
  output logic        nCRDO,
  output logic        nCRDW,
  output logic        nDTACK,
  output logic        BUSY
);

  state_t          state, state_next;
  region_t         region_in, region_q;
  logic            rw_q, uds_n_q, lds_n_q, wen_q;
  strobes_t        strobes_q, strobe_next, active;
  logic            dtack_q, dtack_next;
  logic            latch, cnt_load, cnt_dec, cnt_zero;
  logic [WS_W-1:0] ws_sel;
  logic            addr_unused;

  // Only the top nibble selects a region; WRAM mirrors across the rest.
  assign addr_unused = ^M68K_ADDR[19:1];
  assign region_in   = decode_region(M68K_ADDR[23:20]);
  assign active      = region_strobes(region_q, rw_q, uds_n_q, lds_n_q, wen_q);

  always_comb begin
    ws_sel = '0;
    case (region_in)
      REG_WRAM: ws_sel = WS_W'(WS_WRAM);
      REG_SROM: ws_sel = WS_W'(WS_SROM);
      REG_SRAM: ws_sel = WS_W'(WS_SRAM);
      REG_CARD: ws_sel = WS_W'(WS_CARD);
      default:  ws_sel = '0;
    endcase
  end

  m68k_wait_cnt #(.WS_W(WS_W)) u_wait_cnt (
    .clk      (CLK_24M),
    .rst      (RESET),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (ws_sel),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      region_q  <= REG_NONE;
      rw_q      <= 1'b1;
      uds_n_q   <= 1'b1;
      lds_n_q   <= 1'b1;
      wen_q     <= 1'b0;
      strobes_q <= '0;
      dtack_q   <= 1'b0;
    end else begin
      state     <= state_next;
      strobes_q <= strobe_next;
      dtack_q   <= dtack_next;
      if (latch) begin
        region_q <= region_in;
        rw_q     <= M68K_RW;
        uds_n_q  <= nUDS;
        lds_n_q  <= nLDS;
        wen_q    <= SRAM_WEN;
      end
    end
  end

  // Strobes are the registered image of the next state, so they trail the
  // IDLE->WAIT decision by one edge and drop on the same edge nAS is seen high.
  always_comb begin
    state_next  = state;
    latch       = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    strobe_next = '0;
    dtack_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!nAS && region_in != REG_NONE) begin
          state_next = ST_WAIT;
          latch      = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (nAS) begin
          state_next = ST_HOLD;
        end else begin
          strobe_next = active;
          if (cnt_zero) begin
            dtack_next = 1'b1;
            state_next = ST_ACK;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (nAS) begin
          state_next = ST_HOLD;
        end else begin
          strobe_next = active;
          dtack_next  = 1'b1;
        end
      end
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign nWRAM_OEU = ~strobes_q.wram_oeu;
  assign nWRAM_OEL = ~strobes_q.wram_oel;
  assign nWRAM_WEU = ~strobes_q.wram_weu;
  assign nWRAM_WEL = ~strobes_q.wram_wel;
  assign nSROM_OE  = ~strobes_q.srom_oe;
  assign nSRAM_OEU = ~strobes_q.sram_oeu;
  assign nSRAM_OEL = ~strobes_q.sram_oel;
  assign nSRAM_WEU = ~strobes_q.sram_weu;
  assign nSRAM_WEL = ~strobes_q.sram_wel;
  assign nCRDC     = ~strobes_q.crdc;
  assign nCRDO     = ~strobes_q.crdo;
  assign nCRDW     = ~strobes_q.crdw;
  assign nDTACK    = ~dtack_q;
  assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_m68k_mem_ctrl.sv
// Directed bench for m68k_mem_ctrl: cycle-exact strobe/nDTACK/BUSY checks per region,
// plus unmapped access, abort during WAIT and asynchronous reset during ACK.
module tb_m68k_mem_ctrl;

  logic        CLK_24M;
  logic        RESET;
  logic [23:1] M68K_ADDR;
  logic        M68K_RW;
  logic        nAS, nUDS, nLDS, SRAM_WEN;
  logic        nWRAM_OEU, nWRAM_OEL, nWRAM_WEU, nWRAM_WEL;
  logic        nSROM_OE;
  logic        nSRAM_OEU, nSRAM_OEL, nSRAM_WEU, nSRAM_WEL;
  logic        nCRDC, nCRDO, nCRDW;
  logic        nDTACK, BUSY;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] STRB_IDLE = 12'hFFF;

  m68k_mem_ctrl dut (
    .CLK_24M   (CLK_24M),
    .RESET     (RESET),
    .M68K_ADDR (M68K_ADDR),
    .M68K_RW   (M68K_RW),
    .nAS       (nAS),
    .nUDS      (nUDS),
    .nLDS      (nLDS),
    .SRAM_WEN  (SRAM_WEN),
    .nWRAM_OEU (nWRAM_OEU),
    .nWRAM_OEL (nWRAM_OEL),
    .nWRAM_WEU (nWRAM_WEU),
    .nWRAM_WEL (nWRAM_WEL),
    .nSROM_OE  (nSROM_OE),
    .nSRAM_OEU (nSRAM_OEU),
    .nSRAM_OEL (nSRAM_OEL),
    .nSRAM_WEU (nSRAM_WEU),
    .nSRAM_WEL (nSRAM_WEL),
    .nCRDC     (nCRDC),
    .nCRDO     (nCRDO),
    .nCRDW     (nCRDW),
    .nDTACK    (nDTACK),
    .BUSY      (BUSY)
  );

  initial CLK_24M = 1'b0;
  always #5 CLK_24M = ~CLK_24M;

  // Observed outputs as {12 strobes, nDTACK, BUSY}.
  function automatic logic [13:0] obs();
    return {nWRAM_OEU, nWRAM_OEL, nWRAM_WEU, nWRAM_WEL, nSROM_OE,
            nSRAM_OEU, nSRAM_OEL, nSRAM_WEU, nSRAM_WEL,
            nCRDC, nCRDO, nCRDW, nDTACK, BUSY};
  endfunction

  task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b, want %b", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] byte_addr, input logic rw,
                               input logic uds_n, input logic lds_n, input logic wen);
    @(negedge CLK_24M);
    M68K_ADDR = byte_addr[23:1];
    M68K_RW   = rw;
    nUDS      = uds_n;
    nLDS      = lds_n;
    SRAM_WEN  = wen;
    nAS       = 1'b0;
  endtask

  // Full access; address, RW and SRAM_WEN are scrambled after the latch edge.
  task automatic runAccess(input string tag, input logic [23:0] byte_addr, input logic rw,
                           input logic uds_n, input logic lds_n, input logic wen,
                           input int ws, input logic [11:0] strb);
    applyStimulus(byte_addr, rw, uds_n, lds_n, wen);
    @(negedge CLK_24M);
    checkOutput({tag, " latch"}, obs(), {STRB_IDLE, 1'b1, 1'b1});
    M68K_ADDR = 23'h180000;
    M68K_RW   = ~rw;
    SRAM_WEN  = ~wen;
    for (int i = 0; i <= ws; i++) begin
      @(negedge CLK_24M);
      checkOutput($sformatf("%s wait%0d", tag, i), obs(), {strb, (i == ws) ? 1'b0 : 1'b1, 1'b1});
    end
    @(negedge CLK_24M);
    checkOutput({tag, " ack"}, obs(), {strb, 1'b0, 1'b1});
    nAS  = 1'b1;
    nUDS = 1'b1;
    nLDS = 1'b1;
    @(negedge CLK_24M);
    checkOutput({tag, " release"}, obs(), {STRB_IDLE, 1'b1, 1'b1});
    @(negedge CLK_24M);
    checkOutput({tag, " idle"}, obs(), {STRB_IDLE, 1'b1, 1'b0});
  endtask

  initial begin
    RESET     = 1'b1;
    nAS       = 1'b1;
    nUDS      = 1'b1;
    nLDS      = 1'b1;
    M68K_RW   = 1'b1;
    M68K_ADDR = '0;
    SRAM_WEN  = 1'b0;
    #12;
    checkOutput("reset", obs(), {STRB_IDLE, 1'b1, 1'b0});
    @(negedge CLK_24M);
    RESET = 1'b0;

    runAccess("wram_rd",      24'h100000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12'h3FF);
    runAccess("wram_wr_mir",  24'h1F0002, 1'b0, 1'b0, 1'b0, 1'b1, 0, 12'hCFF);
    runAccess("sram_wr_lo",   24'hD00001, 1'b0, 1'b1, 1'b0, 1'b1, 1, 12'hFF7);
    runAccess("sram_wr_lock", 24'hD00001, 1'b0, 1'b1, 1'b0, 1'b0, 1, 12'hFFF);
    runAccess("sram_rd_hi",   24'hD00000, 1'b1, 1'b0, 1'b1, 1'b0, 1, 12'hFBF);
    runAccess("srom_rd",      24'hC11D46, 1'b1, 1'b0, 1'b0, 1'b1, 2, 12'hF7F);
    runAccess("srom_wr",      24'hC00000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 12'hFFF);
    runAccess("card_rd",      24'h800000, 1'b1, 1'b0, 1'b0, 1'b1, 3, 12'hFF9);
    runAccess("card_wr",      24'hB00000, 1'b0, 1'b0, 1'b0, 1'b1, 3, 12'hFFA);

    applyStimulus(24'h300000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_24M);
      checkOutput($sformatf("none c%0d", i), obs(), {STRB_IDLE, 1'b1, 1'b0});
    end
    nAS = 1'b1;

    applyStimulus(24'hC00000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK_24M);
    checkOutput("abort latch", obs(), {STRB_IDLE, 1'b1, 1'b1});
    @(negedge CLK_24M);
    checkOutput("abort strobe", obs(), {12'hF7F, 1'b1, 1'b1});
    nAS = 1'b1;
    @(negedge CLK_24M);
    checkOutput("abort hold", obs(), {STRB_IDLE, 1'b1, 1'b1});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_24M);
      checkOutput($sformatf("abort idle%0d", i), obs(), {STRB_IDLE, 1'b1, 1'b0});
    end

    applyStimulus(24'h100000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge CLK_24M);
    @(negedge CLK_24M);
    checkOutput("rst pre", obs(), {12'h3FF, 1'b0, 1'b1});
    #2 RESET = 1'b1;
    #1 checkOutput("rst async", obs(), {STRB_IDLE, 1'b1, 1'b0});
    nAS = 1'b1;
    #1 RESET = 1'b0;
    @(negedge CLK_24M);
    checkOutput("rst after", obs(), {STRB_IDLE, 1'b1, 1'b0});
    runAccess("post_rst_rd",  24'h100000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 12'h7FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m68k_mem_ctrl.md
Name: m68k_mem_ctrl

Overview:
- Decodes the 68K bus and sequences the board memories: work RAM, system ROM, backup SRAM and memory card.
- Generates registered chip strobes and a per-region wait-state count, then drives nDTACK back to the CPU.
- Takes over the WRAM/SRAM/SROM control that the top level currently does ad hoc. It is the CPLD-bound half of the board glue logic.

Parameters:
- WS_WRAM, 0, wait cycles (CLK_24M) before nDTACK for work RAM
- WS_SROM, 2, wait cycles for system ROM
- WS_SRAM, 1, wait cycles for backup SRAM
- WS_CARD, 3, wait cycles for memory card
- WS_W, 3, width of the wait counter (must hold the largest WS_*)

Ports:
- CLK_24M  in  1  master clock; 68K bus strobes are sampled on its rising edge
- RESET  in  1  asynchronous, active-high reset
- M68K_ADDR  in  23  CPU address [23:1]
- M68K_RW  in  1  1 = read, 0 = write
- nAS  in  1  address strobe
- nUDS, nLDS  in  1 each  upper/lower data strobes
- SRAM_WEN  in  1  backup SRAM write enable (1 = unlocked)
- nWRAM_OEU, nWRAM_OEL, nWRAM_WEU, nWRAM_WEL  out  1 each  work RAM byte strobes
- nSROM_OE  out  1  system ROM output enable
- nSRAM_OEU, nSRAM_OEL, nSRAM_WEU, nSRAM_WEL  out  1 each  backup SRAM byte strobes
- nCRDC  out  1  memory card select
- nCRDO  out  1  memory card read strobe
- nCRDW  out  1  memory card write strobe
- nDTACK  out  1  data acknowledge to the CPU
- BUSY  out  1  high while any access owned by this block is in progress

Behaviour:
- Decode is on M68K_ADDR[23:20] (byte address):
  - 0x1 → WRAM (mirrored every 64 KiB)
  - 0x8..0xB → CARD
  - 0xC → SROM
  - 0xD → SRAM
  - anything else → NONE
- Reset value of every output: all n* outputs = 1, BUSY = 0, FSM = IDLE, wait counter = 0. Reset applies immediately (asynchronous) even mid-access.
- FSM states are IDLE, WAIT, ACK, HOLD.
- IDLE:
  - When nAS = 0 is sampled with region != NONE, latch region, RW, UDS and LDS, load counter = WS_region, and go to WAIT.
  - The strobes for that region go active at the next edge (1-cycle registered latency).
  - Region NONE: stay in IDLE, drive no outputs; another block acknowledges.
- WAIT:
  - Hold strobes and decrement the counter each cycle.
  - When counter == 0, assert nDTACK = 0 and go to ACK.
  - With WS = 0, nDTACK goes low in the same cycle the strobes go active, i.e. nAS sampled low at edge N gives strobes and nDTACK low after edge N+1.
- ACK: hold strobes and nDTACK = 0 until nAS is sampled high. Then release all strobes and nDTACK together at the next edge and go to HOLD.
- HOLD: one recovery cycle with everything inactive, then IDLE. Back-to-back accesses are therefore separated by at least 1 idle cycle.
- Byte strobes:
  - The U strobe is active only if the latched UDS was 0; likewise L with LDS.
  - A read enables OE, a write enables WE. OE and WE are never both active.
  - SROM is read-only: a write to SROM still acknowledges after WS_SROM cycles but drives no strobe.
- SRAM lock: with SRAM_WEN = 0, a write to SRAM acknowledges normally and the WE strobes stay high. SRAM_WEN is sampled at the IDLE→WAIT transition only.
- CARD: nCRDC is active for the whole access. nCRDO is active on reads, nCRDW on writes. Both follow the latched data strobes (either strobe low → active).
- Abort: if nAS is sampled high while in WAIT, deassert everything at the next edge, never assert nDTACK, and go to HOLD.
- Address or RW changes after latch are ignored until the next IDLE.
- BUSY = 1 in the WAIT, ACK and HOLD states.

Decomposition:
- Shared package mem_map_pkg holds:
  - region enum (NONE, WRAM, CARD, SROM, SRAM)
  - FSM state enum
  - region base constants
  - decode function addr[23:20] → region
- One sub-module, m68k_wait_cnt: loadable down-counter with a zero flag, WS_W bits wide.
- The FSM and strobe registers stay in the top module.

Test Plan:
- Read 0x100000, UDS = LDS = 0, WS_WRAM = 0 → nWRAM_OEU/OEL low at edge N+1, nDTACK low at N+1; all high 1 edge after nAS rises.
- Byte write 0xD00001 (nLDS = 0, nUDS = 1):
  - with SRAM_WEN = 1 → only nSRAM_WEL low, nDTACK after 1 wait cycle.
  - repeated with SRAM_WEN = 0 → no WE pulse, nDTACK still asserted.
- Read 0xC11D46 → nSROM_OE low, nDTACK low exactly 2 cycles after strobe assertion. Write to 0xC00000 → no nSROM_OE, nDTACK still asserted.
- Card read at 0x800000 → nCRDC and nCRDO low, nDTACK after 3 cycles. Card write → nCRDW low and nCRDO high throughout.
- Access to 0x300000 → all outputs idle, BUSY = 0, nDTACK stays 1 for 20 cycles.
- Two cases:
  - Abort: nAS released during SROM WAIT → strobes high next edge, nDTACK never low.
  - Reset: RESET pulsed during ACK → all outputs 1 immediately (asynchronous), FSM in IDLE, next access works normally.
